// File: rtl/xadc_trig_capture.sv
// xadc_trig_capture: XADC sample ring buffer with level/edge trigger and pre-trigger retention
module xadc_trig_capture #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [15:0]       sample_data,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [11:0]       trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, start_q, start_d;
  logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc, post_len;
  logic [11:0] prev_q, prev_d, rd_data_q, rd_data_d, s;
  logic prev_vld_q, prev_vld_d, we, hit;
  logic [11:0] mem [DEPTH];
  always_comb begin
    s = sample_data[15:4];
    cnt_inc = cnt_q + (ADDR_W+1)'(1);
    post_len = {1'b1, {ADDR_W{1'b0}}} - {1'b0, pretrig};
    we = sample_valid && !arm && (state_q inside {PRE, WAIT_TRIG, POST});
    hit = force_trig || (prev_vld_q && (trig_rising ? (prev_q < trig_level && s >= trig_level)
                                                    : (prev_q > trig_level && s <= trig_level)));
    rd_data_d = mem[rd_addr];
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    trig_ptr_d = trig_ptr_q;
    start_d = start_q;
    cnt_d = cnt_q;
    prev_d = prev_q;
    prev_vld_d = prev_vld_q;
    if (arm) begin
      state_d = (pretrig == '0) ? WAIT_TRIG : PRE;
      wr_ptr_d = '0;
      cnt_d = '0;
      prev_vld_d = 1'b0;
    end else if (we) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      case (state_q)
        PRE: begin
          cnt_d = cnt_inc;
          prev_d = s;
          prev_vld_d = 1'b1;
          state_d = (cnt_inc == {1'b0, pretrig}) ? WAIT_TRIG : PRE;
        end
        WAIT_TRIG: begin
          prev_d = s;
          prev_vld_d = 1'b1;
          if (hit) begin
            trig_ptr_d = wr_ptr_q;
            cnt_d = (ADDR_W+1)'(1);
            // A trigger sample can complete the capture by itself when pretrig = DEPTH-1
            state_d = (post_len == (ADDR_W+1)'(1)) ? DONE : POST;
            start_d = (post_len == (ADDR_W+1)'(1)) ? wr_ptr_q - pretrig : start_q;
          end
        end
        POST: begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_len) begin
            state_d = DONE;
            start_d = trig_ptr_q - pretrig;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      trig_ptr_q <= '0;
      start_q <= '0;
      cnt_q <= '0;
      prev_q <= '0;
      prev_vld_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      start_q <= start_d;
      cnt_q <= cnt_d;
      prev_q <= prev_d;
      prev_vld_q <= prev_vld_d;
      rd_data_q <= rd_data_d;
    end
  end
  // Buffer RAM has no reset so it maps onto block RAM
  always_ff @(posedge clk_100MHz) begin
    if (we) mem[wr_ptr_q] <= s;
  end
  assign rd_data = rd_data_q;
  assign busy = state_q inside {PRE, WAIT_TRIG, POST};
  assign done = state_q == DONE;
  assign start_addr = start_q;
endmodule

// File: tb/tb_xadc_trig_capture.sv
// tb_xadc_trig_capture: directed scoreboard bench for xadc_trig_capture with ADDR_W=4
module tb_xadc_trig_capture;
  logic clk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0, arm = 1'b0, force_trig = 1'b0, trig_rising = 1'b1;
  logic [15:0] sample_data = '0;
  logic [11:0] trig_level = 12'h800, rd_data;
  logic [3:0] pretrig = 4'd4, rd_addr = '0, start_addr;
  logic busy, done, rd_issue = 1'b0, rd_pend = 1'b0, done_prev = 1'b0;
  logic [11:0] rd_exp[$];
  logic [3:0] done_exp[$];
  int total = 0, bad = 0;

  xadc_trig_capture #(.ADDR_W(4)) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .force_trig(force_trig), .trig_level(trig_level), .trig_rising(trig_rising),
    .pretrig(pretrig), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic send(input logic [11:0] c);
    repeat (2) @(posedge clk);
    #1 sample_valid = 1'b1;
    sample_data = {c, 4'h5};
    @(posedge clk);
    #1 sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_arm();
    @(posedge clk);
    #1 arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [11:0] e);
    @(posedge clk);
    #1 rd_addr = a;
    rd_issue = 1'b1;
    rd_exp.push_back(e);
    @(posedge clk);
    #1 rd_issue = 1'b0;
  endtask

  always @(posedge clk) rd_pend <= rd_issue;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_scoreboard_empty got=%0h exp=none", rd_data);
      end else chk("rd_data", 32'(rd_data), 32'(rd_exp.pop_front()));
    end
    if (done && !done_prev) begin
      if (done_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 exp=0 t=%0t", $time);
      end else chk("start_addr", 32'(start_addr), 32'(done_exp.pop_front()));
    end
    done_prev <= done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(start_addr), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    force_trig = 1'b1;
    for (int i = 0; i < 3; i++) send(12'h123);
    force_trig = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);

    // Rising ramp, trigger at 0x800 (addr 8), start 4
    do_arm();
    chk("arm_busy", 32'(busy), 1);
    for (int k = 0; k < 19; k++) send(12'((k * 256) & 32'hfff));
    chk("ramp_not_done", 32'(done), 0);
    done_exp.push_back(4'd4);
    send(12'h300);
    chk("ramp_done", 32'(done), 1);
    chk("ramp_busy", 32'(busy), 0);
    force_trig = 1'b1;
    send(12'habc);
    force_trig = 1'b0;
    chk("done_hold", 32'(done), 1);
    chk("done_start_hold", 32'(start_addr), 4);
    for (int i = 0; i < 16; i++) rd(4'((4 + i) & 15), 12'(((4 + i) * 256) & 32'hfff));

    // Falling trigger on 0x300 after 0x500s, pretrig 2
    trig_rising = 1'b0;
    trig_level = 12'h400;
    pretrig = 4'd2;
    do_arm();
    send(12'h500);
    send(12'h500);
    send(12'h300);
    for (int i = 0; i < 12; i++) send(12'h600);
    chk("fall_not_done", 32'(done), 0);
    done_exp.push_back(4'd0);
    send(12'h600);
    chk("fall_done", 32'(done), 1);
    rd(4'd2, 12'h300);

    // Sample equal to level from above triggers; pretrig 0
    pretrig = 4'd0;
    do_arm();
    send(12'h300);
    send(12'h500);
    send(12'h400);
    for (int i = 0; i < 14; i++) send(12'h600);
    chk("eq_not_done", 32'(done), 0);
    done_exp.push_back(4'd2);
    send(12'h600);
    chk("eq_done", 32'(done), 1);

    // Forced trigger on first sample, pretrig 0
    trig_rising = 1'b1;
    trig_level = 12'h800;
    force_trig = 1'b1;
    do_arm();
    for (int i = 0; i < 15; i++) send(12'(i * 17));
    chk("force_not_done", 32'(done), 0);
    done_exp.push_back(4'd0);
    send(12'h0ff);
    chk("force_done", 32'(done), 1);
    force_trig = 1'b0;
    rd(4'd0, 12'h000);
    rd(4'd7, 12'h077);
    rd(4'd15, 12'h0ff);

    // Level never crossed for 5*DEPTH samples, then forced
    pretrig = 4'd3;
    do_arm();
    for (int k = 0; k < 80; k++) send((k & 1) ? 12'h200 : 12'h100);
    chk("nocross_busy", 32'(busy), 1);
    chk("nocross_done", 32'(done), 0);
    force_trig = 1'b1;
    for (int j = 0; j < 12; j++) send(12'(32'h900 + j));
    chk("late_not_done", 32'(done), 0);
    done_exp.push_back(4'd13);
    send(12'h90c);
    chk("late_done", 32'(done), 1);
    force_trig = 1'b0;
    rd(4'd13, 12'h200);
    rd(4'd14, 12'h100);
    rd(4'd0, 12'h900);

    // Arm during POST aborts and restarts at address 0
    pretrig = 4'd4;
    do_arm();
    for (int k = 0; k < 10; k++) send(12'(k * 256));
    chk("post_busy", 32'(busy), 1);
    do_arm();
    chk("abort_busy", 32'(busy), 1);
    chk("abort_done", 32'(done), 0);
    send(12'habc);
    rd(4'd0, 12'habc);
    rd(4'd9, 12'h900);
    for (int i = 0; i < 3; i++) send(12'h100);
    force_trig = 1'b1;
    send(12'h111);
    force_trig = 1'b0;
    send(12'h222);
    send(12'h333);
    chk("pre_reset_busy", 32'(busy), 1);

    // Asynchronous reset mid-POST
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_start", 32'(start_addr), 0);
    chk("arst_rd_data", 32'(rd_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    force_trig = 1'b1;
    for (int i = 0; i < 5; i++) send(12'h777);
    force_trig = 1'b0;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(done), 0);
    do_arm();
    chk("rearm_busy", 32'(busy), 1);

    repeat (3) @(negedge clk);
    chk("rd_queue_drained", 32'(rd_exp.size()), 0);
    chk("done_queue_drained", 32'(done_exp.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
